// File: rtl/fir_hex_display_if.sv
// Sample/display bundle between the FIR filter, the hex digit driver and the segment pins.
// The master drives samples and freeze; the slave (display) drives segments and decimal point.
interface fir_hex_display_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       freeze;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output sample_in,
    output sample_valid,
    output freeze,
    input  seg,
    input  dp
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  freeze,
    output seg,
    output dp
  );
endinterface

// File: rtl/fir_hex_display.sv
// Shows each captured FIR sample on one 7-segment digit: high nibble, optional blank, low nibble, blank.
// Optional feature macro: FIR_DISPLAY_PEAK_HOLD_EN (shadow holds the peak sample between frame loads).
module fir_hex_display #(
  parameter int DIGIT_CYCLES = 5000000,
  parameter int BLANK_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset,
  fir_hex_display_if.slave bus
);

  localparam int DATA_W     = 8;
  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW_HI = 3'd1,
    GAP_HI  = 3'd2,
    SHOW_LO = 3'd3,
    GAP_LO  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]   frame;
  logic                seen;
  logic                take_sample;
  logic                frame_load;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign take_sample = bus.sample_valid & ~bus.freeze;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seen) state_nxt = SHOW_HI;
      SHOW_HI: if (cnt == DIGIT_LAST) state_nxt = (BLANK_CYCLES == 0) ? SHOW_LO : GAP_HI;
      GAP_HI:  if (cnt == BLANK_LAST) state_nxt = SHOW_LO;
      SHOW_LO: if (cnt == DIGIT_LAST) state_nxt = (BLANK_CYCLES == 0) ? SHOW_HI : GAP_LO;
      GAP_LO:  if (cnt == BLANK_LAST) state_nxt = SHOW_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // The frame is captured on the transition into SHOW_HI so both nibbles share one sample.
  assign frame_load = (state_nxt == SHOW_HI) && (state != SHOW_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
    end
  end

  // Capture stage: shadow tracks incoming samples, frame snapshots the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      frame  <= '0;
      seen   <= 1'b0;
    end else begin
      seen <= seen | take_sample;
      if (frame_load) frame <= shadow;
`ifdef FIR_DISPLAY_PEAK_HOLD_EN
      if (frame_load)                               shadow <= take_sample ? bus.sample_in : '0;
      else if (take_sample && bus.sample_in > shadow) shadow <= bus.sample_in;
`else
      if (take_sample) shadow <= bus.sample_in;
`endif
    end
  end

  // Output stage: registered segment drive, one clock behind state/frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.seg <= '0;
      bus.dp  <= 1'b0;
    end else begin
      case (state)
        SHOW_HI: begin
          bus.seg <= hex7(frame[7:4]);
          bus.dp  <= 1'b0;
        end
        SHOW_LO: begin
          bus.seg <= hex7(frame[3:0]);
          bus.dp  <= 1'b1;
        end
        default: begin
          bus.seg <= '0;
          bus.dp  <= 1'b0;
        end
      endcase
    end
  end

endmodule
